// File: rtl/alu_scheduler.sv
// Round-robin front end that lets two requesters share one combinational ALU.
// Each operation takes three cycles: operand issue, result capture, and a held valid/ready response.
module alu_scheduler #(
  parameter int WIDTH  = 4,
  parameter int MODE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [MODE_W-1:0]    req0_mode,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  input  logic [MODE_W-1:0]    req1_mode,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  output logic [MODE_W-1:0]    alu_mode,
  input  logic [2*WIDTH-1:0]   alu_num,
  input  logic                 alu_neg,
  input  logic                 alu_cero,
  input  logic                 alu_carry,
  input  logic                 alu_des,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_num,
  output logic [3:0]           rsp_flags,
  output logic [7:0]           ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, state_nxt;
  logic                last_grant;
  logic                gnt1;
  logic                accept;
  logic [WIDTH-1:0]    in1_p1, in2_p1;
  logic [MODE_W-1:0]   mode_p1;
  logic                id_p1;
  logic [2*WIDTH-1:0]  num_p2;
  logic [3:0]          flags_p2;
  logic                vld_p2;
  logic [7:0]          ops_cnt;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    gnt1       = req1_valid & (~req0_valid | ~last_grant);
    case (state)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~gnt1;
          req1_ready = gnt1;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    vld_p2 = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      in1_p1     <= '0;
      in2_p1     <= '0;
      mode_p1    <= '0;
      id_p1      <= 1'b0;
      num_p2     <= '0;
      flags_p2   <= '0;
      ops_cnt    <= '0;
    end else begin
      state <= state_nxt;
      // p1: winning operands drive the ALU for the whole EXEC cycle
      if (accept) begin
        in1_p1     <= gnt1 ? req1_a    : req0_a;
        in2_p1     <= gnt1 ? req1_b    : req0_b;
        mode_p1    <= gnt1 ? req1_mode : req0_mode;
        id_p1      <= gnt1;
        last_grant <= gnt1;
      end
      // p2: ALU result and flags captured at the end of EXEC
      if (state == EXEC) begin
        num_p2   <= alu_num;
        flags_p2 <= {alu_neg, alu_cero, alu_carry, alu_des};
      end
      if (vld_p2 && rsp_ready) ops_cnt <= ops_cnt + 8'd1;
    end
  end

  assign alu_in1   = in1_p1;
  assign alu_in2   = in2_p1;
  assign alu_mode  = mode_p1;
  assign rsp_valid = vld_p2;
  assign rsp_id    = id_p1;
  assign rsp_num   = num_p2;
  assign rsp_flags = flags_p2;
  assign ops_done  = ops_cnt;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: ALU stub {in1,in2} / flags=mode, cycle model plus directed literal checks.
module tb_alu_scheduler;
  localparam int WIDTH  = 4;
  localparam int MODE_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [MODE_W-1:0] req0_mode = '0, req1_mode = '0;
  logic [WIDTH-1:0] alu_in1, alu_in2;
  logic [MODE_W-1:0] alu_mode;
  logic [2*WIDTH-1:0] alu_num;
  logic alu_neg, alu_cero, alu_carry, alu_des;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic rsp_id;
  logic [2*WIDTH-1:0] rsp_num;
  logic [3:0] rsp_flags;
  logic [7:0] ops_done;

  always #5 clk = ~clk;

  assign alu_num = {alu_in1, alu_in2};
  assign {alu_neg, alu_cero, alu_carry, alu_des} = alu_mode;

  alu_scheduler #(.WIDTH(WIDTH), .MODE_W(MODE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode),
    .alu_num(alu_num), .alu_neg(alu_neg), .alu_cero(alu_cero), .alu_carry(alu_carry), .alu_des(alu_des),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_num(rsp_num),
    .rsp_flags(rsp_flags), .ops_done(ops_done)
  );

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc_cnt);
    end
  endtask

  // Behavioural model: an accepted operation is busy for `age` 1 (ALU) then 2 (responding).
  int         age = 0;
  bit         started = 0;
  logic       m_last;
  logic [7:0] m_ops;
  logic [WIDTH-1:0] m_in1, m_in2;
  logic [MODE_W-1:0] m_mode;
  logic       m_id;
  logic [2*WIDTH-1:0] m_num;
  logic [3:0] m_flags;

  always @(posedge clk) begin
    cyc_cnt++;
    if (!rst_n) begin
      started = 1; age = 0; m_last = 1'b1; m_ops = 8'd0;
      m_in1 = '0; m_in2 = '0; m_mode = '0; m_id = 1'b0; m_num = '0; m_flags = '0;
    end else if (age == 0) begin
      if (req0_valid || req1_valid) begin
        m_id  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        m_in1 = m_id ? req1_a : req0_a;
        m_in2 = m_id ? req1_b : req0_b;
        m_mode = m_id ? req1_mode : req0_mode;
        m_last = m_id;
        age = 1;
      end
    end else if (age == 1) begin
      m_num = {m_in1, m_in2};
      m_flags = m_mode;
      age = 2;
    end else if (rsp_ready) begin
      m_ops = m_ops + 8'd1;
      age = 0;
    end
  end

  int   acc_cyc[$];
  logic acc_id[$];
  logic [7:0] rsp_q[$];

  always @(negedge clk) begin
    if (started) begin
      check("req0_ready", 32'(req0_ready), 32'(rst_n && age == 0 && req0_valid && (!req1_valid || m_last)));
      check("req1_ready", 32'(req1_ready), 32'(rst_n && age == 0 && req1_valid && (!req0_valid || !m_last)));
      check("alu_in1", 32'(alu_in1), 32'(m_in1));
      check("alu_in2", 32'(alu_in2), 32'(m_in2));
      check("alu_mode", 32'(alu_mode), 32'(m_mode));
      check("rsp_valid", 32'(rsp_valid), 32'(age == 2));
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_num", 32'(rsp_num), 32'(m_num));
      check("rsp_flags", 32'(rsp_flags), 32'(m_flags));
      check("ops_done", 32'(ops_done), 32'(m_ops));
      if (req0_valid && req0_ready) begin acc_cyc.push_back(cyc_cnt); acc_id.push_back(1'b0); end
      if (req1_valid && req1_ready) begin acc_cyc.push_back(cyc_cnt); acc_id.push_back(1'b1); end
      if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_num);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with a request pending that must not see ready
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd1; req0_mode = 4'd5;
    cyc(2);
    check("lit rst req0_ready", 32'(req0_ready), 32'd0);
    check("lit rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("lit rst ops_done", 32'(ops_done), 32'd0);
    check("lit rst alu_in1", 32'(alu_in1), 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    cyc(1);

    // Single op from req0
    req0_valid = 1'b1;
    #1;
    check("lit t1 req0_ready", 32'(req0_ready), 32'd1);
    cyc(1);
    req0_valid = 1'b0;
    check("lit t1 exec rsp_valid", 32'(rsp_valid), 32'd0);
    cyc(1);
    check("lit t1 rsp_valid", 32'(rsp_valid), 32'd1);
    check("lit t1 rsp_num", 32'(rsp_num), 32'h51);
    check("lit t1 rsp_flags", 32'(rsp_flags), 32'b0101);
    check("lit t1 rsp_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    cyc(1);
    check("lit t1 ops_done", 32'(ops_done), 32'd1);
    check("lit t1 idle rsp_valid", 32'(rsp_valid), 32'd0);

    // Both requesters valid continuously: alternating grants every 3 cycles
    do_reset();
    acc_cyc.delete(); acc_id.delete(); rsp_q.delete();
    req0_a = 4'd4; req0_b = 4'd5; req0_mode = 4'd3;
    req1_a = 4'd2; req1_b = 4'd7; req1_mode = 4'd9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cyc(12);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("lit rr accepts", 32'(acc_id.size()), 32'd4);
    check("lit rr responses", 32'(rsp_q.size()), 32'd4);
    if (acc_id.size() == 4 && rsp_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("lit rr id", 32'(acc_id[i]), 32'(i % 2));
        check("lit rr num", 32'(rsp_q[i]), (i % 2 == 0) ? 32'h45 : 32'h27);
        if (i > 0) check("lit rr spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
      end
    end

    // Only req1 valid after a req1 win: granted again
    req1_valid = 1'b1;
    #1;
    check("lit solo req1_ready", 32'(req1_ready), 32'd1);
    cyc(1);
    req1_valid = 1'b0;
    cyc(1);
    check("lit solo rsp_id", 32'(rsp_id), 32'd1);
    check("lit solo rsp_num", 32'(rsp_num), 32'h27);
    cyc(1);
    check("lit solo ops_done", 32'(ops_done), 32'd5);

    // Backpressure: response held for 10 cycles, req1 keeps waiting
    rsp_ready = 1'b0;
    req0_a = 4'd3; req0_b = 4'd9; req0_mode = 4'd12;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cyc(1);
    req0_valid = 1'b0;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      check("lit bp rsp_valid", 32'(rsp_valid), 32'd1);
      check("lit bp rsp_num", 32'(rsp_num), 32'h39);
      check("lit bp rsp_flags", 32'(rsp_flags), 32'hC);
      check("lit bp req1_ready", 32'(req1_ready), 32'd0);
      cyc(1);
    end
    check("lit bp ops_held", 32'(ops_done), 32'd5);
    rsp_ready = 1'b1;
    cyc(1);
    check("lit bp ops_done", 32'(ops_done), 32'd6);
    check("lit bp req1 next", 32'(req1_ready), 32'd1);
    cyc(1);
    req1_valid = 1'b0;
    cyc(2);
    check("lit bp ops_after", 32'(ops_done), 32'd7);

    // Reset during EXEC drops the operation
    req0_a = 4'd6; req0_b = 4'd2; req0_mode = 4'd1;
    req0_valid = 1'b1;
    cyc(1);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    cyc(1);
    check("lit rx rsp_valid", 32'(rsp_valid), 32'd0);
    check("lit rx ops_done", 32'(ops_done), 32'd0);
    check("lit rx rsp_num", 32'(rsp_num), 32'd0);
    check("lit rx alu_in1", 32'(alu_in1), 32'd0);
    rst_n = 1'b1;
    rsp_q.delete();
    req0_valid = 1'b1;
    cyc(1);
    req0_valid = 1'b0;
    cyc(2);
    check("lit rx ops_done after", 32'(ops_done), 32'd1);
    check("lit rx rsp count", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() == 1) check("lit rx rsp num", 32'(rsp_q[0]), 32'h62);

    // 256 completions wrap ops_done to 0
    do_reset();
    rsp_q.delete();
    req0_valid = 1'b1;
    cyc(766);
    check("lit wrap 255", 32'(ops_done), 32'd255);
    cyc(2);
    req0_valid = 1'b0;
    check("lit wrap 0", 32'(ops_done), 32'd0);
    check("lit wrap count", 32'(rsp_q.size()), 32'd256);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
